// File: rtl/sa_ram_ctrl_pkg.sv
// Shared constants and types for the SA buffer RAM and its show-ahead FIFO controller.
package sa_ram_ctrl_pkg;

  localparam int unsigned SA_RAM_AW    = 5;
  localparam int unsigned SA_RAM_DW    = 128;
  localparam int unsigned SA_RAM_DEPTH = 32;

  typedef logic [SA_RAM_AW-1:0] sa_ram_addr_t;
  typedef logic [SA_RAM_AW:0]   sa_ram_cnt_t;

endpackage

// File: rtl/sa_ram_rws_fifo_ctrl.sv
// Show-ahead FIFO controller for one sa_ram_rws_32x128 RAM (registered read address).
// Owns the pointers, the occupancy and the RAM enables; the RAM itself lives in the parent.
module sa_ram_rws_fifo_ctrl
  import sa_ram_ctrl_pkg::*;
#(
  parameter int unsigned AW        = SA_RAM_AW,
  parameter int unsigned DW        = SA_RAM_DW,
  parameter int unsigned AFULL_LVL = 28
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          afull,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [AW:0] FullCnt  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AfullCnt = (AW + 1)'(AFULL_LVL);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          out_vld_q, out_vld_d;

  logic push, pop, fetch;

  // The presented head still occupies a slot until popped, so count includes it.
  assign count    = ram_cnt_q + {{AW{1'b0}}, out_vld_q};
  assign afull    = (count >= AfullCnt);
  assign wr_ready = (count < FullCnt) && !clr;

  assign push  = wr_valid && wr_ready;
  assign pop   = out_vld_q && rd_ready;
  assign fetch = (ram_cnt_q != '0) && (!out_vld_q || pop) && !clr;

  assign ram_we = push;
  assign ram_wa = wptr_q;
  assign ram_di = wr_data;
  assign ram_re = fetch;
  assign ram_ra = rptr_q;

  // RAM holds its read address until the next re, so dout is stable while presented.
  assign rd_valid = out_vld_q;
  assign rd_data  = ram_dout;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ram_cnt_d = ram_cnt_q;
    out_vld_d = out_vld_q;
    if (clr) begin
      // A pop in the flush cycle is simply absorbed by clearing out_vld.
      wptr_d    = '0;
      rptr_d    = '0;
      ram_cnt_d = '0;
      out_vld_d = 1'b0;
    end else begin
      wptr_d    = wptr_q + AW'(push);
      rptr_d    = rptr_q + AW'(fetch);
      ram_cnt_d = ram_cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, fetch};
      if (fetch) begin
        out_vld_d = 1'b1;
      end else if (pop) begin
        out_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ram_cnt_q <= ram_cnt_d;
      out_vld_q <= out_vld_d;
    end
  end

endmodule

// File: doc/sa_ram_rws_fifo_ctrl.md
Name: sa_ram_rws_fifo_ctrl

Overview:
Show-ahead FIFO controller that sequences one sa_ram_rws_32x128 two-port RAM (separate write port; registered read address, so data is valid on the cycle after the read enable).
- Owns the write/read pointers, the occupancy count and the RAM enables.
- Presents valid/ready streams on both sides.
- Instantiated next to the RAM inside SA buffer wrappers; the RAM stays a separate instance.

Parameters:
AW, 5, RAM address width (depth = 2**AW = 32); only the default is supported.
DW, 128, data width; must match the RAM.
AFULL_LVL, 28, occupancy at or above which afull asserts (range 1..32).

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous active-high reset
clr  in  1  synchronous flush
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_data  in  DW  write payload
rd_valid  out  1  head entry presented
rd_ready  in  1  consumer takes head when rd_valid && rd_ready
rd_data  out  DW  head payload (= ram_dout)
count  out  AW+1  total occupancy 0..32
afull  out  1  count >= AFULL_LVL
ram_wa  out  AW  to RAM wa
ram_we  out  1  to RAM we
ram_di  out  DW  to RAM di
ram_ra  out  AW  to RAM ra
ram_re  out  1  to RAM re
ram_dout  in  DW  from RAM dout

Behaviour:
- Reset (async, rst=1): wptr=0, rptr=0, ram_cnt=0, out_vld=0.
  - Outputs during/after reset: count=0, rd_valid=0, wr_ready=1, afull=0, ram_we=0, ram_re=0.
- State:
  - wptr, rptr: AW-bit, wrap 31->0 naturally.
  - ram_cnt: 0..32, entries written but not yet fetched.
  - out_vld: head fetched and being presented.
  - count = ram_cnt + out_vld.
- Write path:
  - wr_ready = (count < 32) && !clr.
  - push = wr_valid && wr_ready.
  - ram_we = push, ram_wa = wptr, ram_di = wr_data, all combinational.
  - wptr increments on push.
- Fetch path:
  - pop = rd_valid && rd_ready.
  - fetch = (ram_cnt != 0) && (!out_vld || pop) && !clr.
  - ram_re = fetch, ram_ra = rptr; rptr increments on fetch.
- out_vld next value:
  - set to 1 on fetch;
  - else cleared on pop;
  - else held.
- rd_valid = out_vld; rd_data = ram_dout, which stays stable while held because the RAM keeps ra_d until the next re.
- ram_cnt next = ram_cnt + push - fetch. Simultaneous push and fetch leaves it unchanged.
- Slot protection: the presented slot counts in count until popped, so the writer can never overwrite the entry on rd_data. Full is count == 32.
- Latency:
  - Write into an empty FIFO at cycle t: ram_cnt=1 at t+1, fetch at t+1, rd_valid=1 at t+2.
  - Back-to-back pop with ram_cnt > 0: the next head is valid the following cycle, giving 1 entry/cycle sustained throughput.
- Simultaneous push and pop when full: pop frees a slot only from the next cycle; wr_ready stays 0 in that cycle, with no combinational ready-through.
- clr=1:
  - Next edge sets wptr=rptr=0, ram_cnt=0, out_vld=0.
  - wr_ready=0 and no fetch in the clr cycle.
  - A pop in that cycle is still considered consumed.
  - RAM contents are not cleared.
- rst asserted mid-operation: immediate return to reset values. The RAM is not reset; stale data is unreachable.
- Illegal stimulus: wr_valid while !wr_ready is ignored (not stored). No read is ever issued when ram_cnt == 0.

Decomposition:
- Shared package sa_ram_ctrl_pkg holds:
  - constants SA_RAM_AW=5, SA_RAM_DW=128, SA_RAM_DEPTH=32;
  - typedef sa_ram_addr_t (AW bits) and sa_ram_cnt_t (AW+1 bits).
- Single module; no sub-module. The RAM is instantiated by the parent.

Test Plan:
1. Reset, then write 0xA at t0 with rd_ready=0 -> ram_we=1, ram_wa=0 at t0; rd_valid=1 at t0+2 with rd_data=0xA; count=1.
2. Write 32 words (values 0..31) back-to-back with rd_ready=0 -> wr_ready drops once count=32; afull asserts when count reaches 28; a 33rd wr_valid is ignored.
3. From full, hold rd_ready=1 -> 32 pops, one per cycle, values 0..31 in order; rd_valid drops after the last pop; count=0.
4. Write 40 words streaming with rd_ready=1 -> pointers wrap 31->0 without corruption; output order 0..39; count never exceeds 2.
5. Full FIFO with simultaneous wr_valid and pop -> wr_ready=0 that cycle; write accepted next cycle; count returns to 32.
6. count=10 with clr=1 for one cycle -> count=0, rd_valid=0 next cycle; then write 0x55 -> read back 0x55. Also: async rst mid-stream -> outputs at reset values immediately.
